// File: rtl/tcp_rx_notify_reader_if.sv
// ----------------------------------------------------------------------------
// Stream interfaces used by tcp_rx_notify_reader.
//
// axis_meta_if  : valid/ready handshake carrying a DATA_W-bit metadata word.
//   master drives valid/data and receives ready; slave is the reverse.
// axi_stream_if : valid/ready handshake carrying a DATA_W-bit data beat with
//   byte keep and last. master drives valid/data/keep/last; slave drives ready.
// ----------------------------------------------------------------------------
interface axis_meta_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

interface axi_stream_if #(
    parameter int DATA_W = 512,
    parameter int KEEP_W = DATA_W / 8
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;

    modport master (output valid, output data, output keep, output last, input  ready);
    modport slave  (input  valid, input  data, input  keep, input  last, output ready);
endinterface

// File: rtl/tcp_rx_notify_reader.sv
// ----------------------------------------------------------------------------
// tcp_rx_notify_reader
//
// Queues TCP receive notifications, turns each non-empty one into a read
// request to the TCP stack, then forwards the stack's session/meta and payload
// towards dma_get_data_from_net. One transfer is in flight at a time.
//
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   s_axis_notification    88-bit notification {closed,port,ip,length,session}
//   m_axis_read_package    32-bit read request {length,session}
//   s_axis_stack_rx_meta   16-bit session returned by the stack before data
//   s_axis_stack_rx_data   512-bit payload from the stack
//   m_axis_rx_metadata     stored 88-bit notification, forwarded downstream
//   m_axis_rx_data         512-bit payload, forwarded downstream
//   status_reg             [0] read requests, [1] zero-length drops,
//                          [2] session mismatches (all wrap modulo 2^32)
// ----------------------------------------------------------------------------
module tcp_rx_notify_reader #(
    parameter int FIFO_DEPTH_BITS = 4,
    parameter int BEAT_BYTES      = 64
) (
    input  logic             clk,
    input  logic             rstn,
    axis_meta_if.slave       s_axis_notification,
    axis_meta_if.master      m_axis_read_package,
    axis_meta_if.slave       s_axis_stack_rx_meta,
    axi_stream_if.slave      s_axis_stack_rx_data,
    axis_meta_if.master      m_axis_rx_metadata,
    axi_stream_if.master     m_axis_rx_data,
    output logic [2:0][31:0] status_reg
);

    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam int PTR_W = FIFO_DEPTH_BITS + 1;

    typedef struct packed {
        logic [7:0]  closed;
        logic [15:0] port;
        logic [31:0] ip;
        logic [15:0] length;
        logic [15:0] session;
    } notif_t;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        REQ,
        META,
        DATA
    } state_e;

    // ------------------------------------------------------------------------
    // Notification FIFO
    // ------------------------------------------------------------------------
    notif_t           fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;

    // Held low through reset and for the first cycle after it, so no
    // notification is accepted while the block is still coming out of reset.
    logic             accept_en_q;

    state_e           state_q;
    state_e           state_d;
    notif_t           entry_q;
    logic [16:0]      beats_q;
    logic [16:0]      beats_d;
    logic [15:0]      beat_cnt_q;
    logic [15:0]      beat_cnt_d;
    logic [31:0]      req_cnt_q;
    logic [31:0]      req_cnt_d;
    logic [31:0]      drop_cnt_q;
    logic [31:0]      drop_cnt_d;
    logic [31:0]      mis_cnt_q;
    logic [31:0]      mis_cnt_d;
    logic             last_beat;
    logic             unused_in_last;

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // indices with differing wrap bits mean full.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FIFO_DEPTH_BITS] != rd_ptr_q[FIFO_DEPTH_BITS]) &&
                        (wr_ptr_q[FIFO_DEPTH_BITS-1:0] == rd_ptr_q[FIFO_DEPTH_BITS-1:0]);

    assign s_axis_notification.ready = accept_en_q && !fifo_full;
    assign push = s_axis_notification.valid && s_axis_notification.ready;
    assign pop  = (state_q == IDLE) && !fifo_empty;

    // NOTE: the storage array has no reset; emptiness is defined by the
    // pointers alone, so clearing the contents would only cost area.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[FIFO_DEPTH_BITS-1:0]] <= s_axis_notification.data;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            entry_q     <= '0;
            accept_en_q <= 1'b0;
            state_q     <= IDLE;
            beats_q     <= '0;
            beat_cnt_q  <= '0;
            req_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            mis_cnt_q   <= '0;
        end else begin
            accept_en_q <= 1'b1;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                entry_q  <= fifo_mem[rd_ptr_q[FIFO_DEPTH_BITS-1:0]];
            end
            state_q    <= state_d;
            beats_q    <= beats_d;
            beat_cnt_q <= beat_cnt_d;
            req_cnt_q  <= req_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            mis_cnt_q  <= mis_cnt_d;
        end
    end

    // The downstream last flag is generated from the beat count; the stack's
    // own last is deliberately ignored.
    assign unused_in_last = s_axis_stack_rx_data.last;
    assign last_beat      = ({1'b0, beat_cnt_q} == (beats_q - 17'd1));

    // ------------------------------------------------------------------------
    // Transfer FSM: next state, counters and all handshake outputs
    // ------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        beats_d    = beats_q;
        beat_cnt_d = beat_cnt_q;
        req_cnt_d  = req_cnt_q;
        drop_cnt_d = drop_cnt_q;
        mis_cnt_d  = mis_cnt_q;

        m_axis_read_package.valid  = 1'b0;
        m_axis_read_package.data   = {entry_q.length, entry_q.session};
        s_axis_stack_rx_meta.ready = 1'b0;
        m_axis_rx_metadata.valid   = 1'b0;
        m_axis_rx_metadata.data    = entry_q;
        s_axis_stack_rx_data.ready = 1'b0;
        m_axis_rx_data.valid       = 1'b0;
        m_axis_rx_data.data        = s_axis_stack_rx_data.data;
        m_axis_rx_data.keep        = s_axis_stack_rx_data.keep;
        m_axis_rx_data.last        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = POP;
                end
            end

            POP: begin
                if (entry_q.length == 16'd0) begin
                    drop_cnt_d = drop_cnt_q + 32'd1;
                    state_d    = IDLE;
                end else begin
                    // 17-bit ceiling division keeps length 0xFFFF from wrapping.
                    beats_d = (17'(entry_q.length) + 17'(BEAT_BYTES - 1)) / 17'(BEAT_BYTES);
                    state_d = REQ;
                end
            end

            REQ: begin
                m_axis_read_package.valid = 1'b1;
                if (m_axis_read_package.ready) begin
                    req_cnt_d = req_cnt_q + 32'd1;
                    state_d   = META;
                end
            end

            META: begin
                // Stack meta and forwarded metadata complete together: each
                // side's ready follows the other side's readiness.
                s_axis_stack_rx_meta.ready = m_axis_rx_metadata.ready;
                m_axis_rx_metadata.valid   = s_axis_stack_rx_meta.valid;
                if (s_axis_stack_rx_meta.valid && m_axis_rx_metadata.ready) begin
                    if (s_axis_stack_rx_meta.data != entry_q.session) begin
                        mis_cnt_d = mis_cnt_q + 32'd1;
                    end
                    state_d = DATA;
                end
            end

            DATA: begin
                m_axis_rx_data.valid       = s_axis_stack_rx_data.valid;
                s_axis_stack_rx_data.ready = m_axis_rx_data.ready;
                m_axis_rx_data.last        = last_beat;
                if (s_axis_stack_rx_data.valid && m_axis_rx_data.ready) begin
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 16'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign status_reg[0] = req_cnt_q;
    assign status_reg[1] = drop_cnt_q;
    assign status_reg[2] = mis_cnt_q;

endmodule

// File: doc/tcp_rx_notify_reader.md
TCP_RX_NOTIFY_READER -- requirements
Module: tcp_rx_notify_reader

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH_BITS, default 4, giving the notification FIFO depth as 2^FIFO_DEPTH_BITS entries.
REQ-002 The block SHALL have parameter BEAT_BYTES, default 64, giving the bytes per 512-bit data beat.
REQ-003 clk  in  1  single clock for the whole block.
REQ-004 rstn  in  1  reset; asynchronous, active-low.
REQ-005 s_axis_notification  in  axis_meta 88  TCP notification, fields {closed[87:80], port[79:64], ip[63:32], length[31:16], session[15:0]}.
REQ-006 m_axis_read_package  out  axis_meta 32  read request to the TCP stack, fields {length[31:16], session[15:0]}.
REQ-007 s_axis_stack_rx_meta  in  axis_meta 16  session ID that the stack returns ahead of the data.
REQ-008 s_axis_stack_rx_data  in  axi_stream 512  payload data from the stack.
REQ-009 m_axis_rx_metadata  out  axis_meta 88  stored notification, forwarded to dma_get_data_from_net.
REQ-010 m_axis_rx_data  out  axi_stream 512  payload data, forwarded to dma_get_data_from_net.
REQ-011 status_reg  out  3x32  [0] read requests issued, [1] zero-length notifications dropped, [2] session mismatches.

Function
REQ-012 s_axis_notification.ready SHALL equal the inverse of FIFO full; a notification is pushed on a valid&&ready handshake.
REQ-013 The FSM SHALL have the states IDLE, POP, REQ, META, DATA, and its reset state SHALL be IDLE.
REQ-014 IDLE: when the FIFO is not empty, the block SHALL pop one entry and go to POP; the entry is registered in POP.
REQ-015 POP: if length==0, the block SHALL drop the entry, increment status_reg[1] and return to IDLE; otherwise it SHALL go to REQ.
REQ-016 REQ: m_axis_read_package.valid SHALL be 1 with data {length,session} until ready is seen; on that handshake the block SHALL increment status_reg[0] and go to META.
REQ-017 META: s_axis_stack_rx_meta.ready SHALL be 1 only in META, and m_axis_rx_metadata SHALL present the stored 88-bit entry.
REQ-018 META: the stack meta SHALL be consumed only in a cycle where m_axis_rx_metadata.ready=1; both handshakes SHALL complete in the same cycle, after which the block goes to DATA.
REQ-019 If the stack session differs from the stored session, the block SHALL increment status_reg[2] and continue normally.
REQ-020 Beat count SHALL be beats = (length + BEAT_BYTES-1) / BEAT_BYTES, computed in 17 bits so that length 0xFFFF does not overflow.
REQ-021 DATA: m.valid SHALL equal s.valid and s.ready SHALL equal m.ready, with data and keep passed combinationally and zero added latency.
REQ-022 DATA: a 16-bit beat counter SHALL count handshakes, and m_axis_rx_data.last SHALL be 1 on the beat where counter == beats-1, regardless of the input last.
REQ-023 After the last handshake the block SHALL clear the counter and return to IDLE.
REQ-024 s_axis_stack_rx_data.ready SHALL be 0 outside DATA.
REQ-025 A push and a pop in the same cycle SHALL leave the FIFO count unchanged.
REQ-026 A push while the FIFO is full SHALL be impossible, because ready is 0.
REQ-027 The status counters SHALL wrap modulo 2^32.
REQ-028 Only one transfer SHALL be outstanding at a time.

Reset
REQ-029 While rstn=0, all valid/ready outputs, status_reg, the beat counter, the FIFO pointers and the FSM state SHALL be 0/IDLE, and the FIFO SHALL be empty.
REQ-030 Assertion of rstn mid-transfer SHALL abort the transfer immediately and discard all queued notifications.
REQ-031 The first notification accepted after reset release SHALL be accepted one cycle after rstn rises at the earliest.

Verification
REQ-032 Notification {0,0x1234,0x010bd1d4,0x0040,0x0002} -> read request 0x00400002, then metadata forwarded, then 1 data beat with last=1, and status_reg[0]=1.
REQ-033 Length 0x0400 with m_axis_rx_data.ready toggled every cycle -> exactly 16 beats, last only on the 16th, and data unchanged under stall.
REQ-034 Length 0x0041 -> 2 beats; length 0xFFFF -> 1024 beats with no overflow.
REQ-035 Closed notification {0xff,...,length 0} -> no read request, status_reg[1]=1, and the next notification is processed.
REQ-036 Push 20 back-to-back notifications with FIFO_DEPTH_BITS=4 and read_package.ready=0 -> notification ready deasserts when full, no loss, and all 20 requests are issued in order once ready=1.
REQ-037 Stack meta session 0x0003 for a request with session 0x0002 -> status_reg[2]=1 and the data still forwarded; rstn pulsed during DATA -> all outputs 0 and the FIFO empty.
